// File: rtl/gestor_carga_baterias.sv
// ---------------------------------------------------------------------------
// gestor_carga_baterias
//
// Drives the writer side of the two 4-bit battery-charge buses read by the
// charge-level monitor. It holds the charge of two batteries and simulates
// them over time: charging from an external charger, discharging under load,
// and balancing the pair. Each step lands every PASO_TICKS clocks. Charging
// always fills the emptier battery. Discharging always drains the fuller one.
//
// Ports:
//   clk            - system clock, rising edge
//   rst_n          - asynchronous active-low reset
//   cargar         - charger connected (level); has priority over consumo
//   consumo        - load active (level)
//   carga_bateria1 - battery 1 charge register
//   carga_bateria2 - battery 2 charge register
//   estado         - 0=REPOSO, 1=CARGANDO, 2=DESCARGANDO, 3=AGOTADO
//   llena          - both batteries at CARGA_MAX
//   vacia          - both batteries at 0
//   actualizado    - registered pulse, high in the cycle a new charge appears
// ---------------------------------------------------------------------------
module gestor_carga_baterias #(
    parameter int CARGA_MAX  = 15,
    parameter int CARGA_INI  = 15,
    parameter int PASO_TICKS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cargar,
    input  logic       consumo,
    output logic [3:0] carga_bateria1,
    output logic [3:0] carga_bateria2,
    output logic [1:0] estado,
    output logic       llena,
    output logic       vacia,
    output logic       actualizado
);

    localparam int              TW        = $clog2(PASO_TICKS) + 1;
    localparam logic [3:0]      MAX4      = 4'(CARGA_MAX);
    localparam logic [3:0]      INI4      = 4'(CARGA_INI);
    localparam logic [TW-1:0]   TICK_LAST = TW'(PASO_TICKS - 1);

    typedef enum logic [1:0] {
        REPOSO      = 2'd0,
        CARGANDO    = 2'd1,
        DESCARGANDO = 2'd2,
        AGOTADO     = 2'd3
    } estado_t;

    estado_t       state, state_next;
    logic [TW-1:0] tick, tick_next;
    logic [3:0]    c1_next, c2_next;
    logic          paso;

    // Status flags are decoded straight from the charge registers.
    assign llena  = (carga_bateria1 == MAX4) && (carga_bateria2 == MAX4);
    assign vacia  = (carga_bateria1 == 4'd0) && (carga_bateria2 == 4'd0);
    assign estado = state;
    assign paso   = (tick == TICK_LAST);

    // Next-state, tick counter and charge update logic.
    // Explicit transitions (from cargar/consumo) take priority over a step.
    // When one fires, it cancels the step on that edge. The only transition
    // that coexists with a step is DESCARGANDO -> AGOTADO. That transition
    // happens on the edge where the step empties the last unit.
    always_comb begin
        state_next = state;
        tick_next  = tick;
        c1_next    = carga_bateria1;
        c2_next    = carga_bateria2;

        case (state)
            REPOSO: begin
                if (cargar)
                    state_next = CARGANDO;
                else if (consumo)
                    state_next = vacia ? AGOTADO : DESCARGANDO;
            end

            CARGANDO: begin
                if (!cargar) begin
                    if (consumo)
                        state_next = vacia ? AGOTADO : DESCARGANDO;
                    else
                        state_next = REPOSO;
                end else if (!paso) begin
                    tick_next = tick + 1'b1;
                end else begin
                    tick_next = '0;
                    // The lower battery is charged; on a tie, battery 1.
                    // A battery that is already full hands the step to
                    // the other battery.
                    if (!llena) begin
                        if (carga_bateria1 <= carga_bateria2) begin
                            if (carga_bateria1 < MAX4)
                                c1_next = carga_bateria1 + 4'd1;
                            else if (carga_bateria2 < MAX4)
                                c2_next = carga_bateria2 + 4'd1;
                        end else begin
                            if (carga_bateria2 < MAX4)
                                c2_next = carga_bateria2 + 4'd1;
                            else if (carga_bateria1 < MAX4)
                                c1_next = carga_bateria1 + 4'd1;
                        end
                    end
                end
            end

            DESCARGANDO: begin
                if (cargar) begin
                    state_next = CARGANDO;
                end else if (!consumo) begin
                    state_next = REPOSO;
                end else if (!paso) begin
                    tick_next = tick + 1'b1;
                end else begin
                    tick_next = '0;
                    // The higher battery is drained; on a tie, battery 1.
                    // Both decrements saturate at zero.
                    if (carga_bateria1 >= carga_bateria2) begin
                        if (carga_bateria1 != 4'd0)
                            c1_next = carga_bateria1 - 4'd1;
                    end else if (carga_bateria2 != 4'd0) begin
                        c2_next = carga_bateria2 - 4'd1;
                    end
                    if ((c1_next == 4'd0) && (c2_next == 4'd0))
                        state_next = AGOTADO;
                end
            end

            AGOTADO: begin
                if (cargar)
                    state_next = CARGANDO;
            end

            default: state_next = REPOSO;
        endcase

        // Every state change restarts step timing from zero.
        if (state_next != state)
            tick_next = '0;
    end

    // State, tick counter and charge registers, plus the update strobe.
    // The strobe is high whenever either charge register changes value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= REPOSO;
            tick           <= '0;
            carga_bateria1 <= INI4;
            carga_bateria2 <= INI4;
            actualizado    <= 1'b0;
        end else begin
            state          <= state_next;
            tick           <= tick_next;
            carga_bateria1 <= c1_next;
            carga_bateria2 <= c2_next;
            actualizado    <= (c1_next != carga_bateria1) ||
                              (c2_next != carga_bateria2);
        end
    end

endmodule

// File: tb/tb_gestor_carga_baterias.sv
// ---------------------------------------------------------------------------
// tb_gestor_carga_baterias
//
// Directed bench for gestor_carga_baterias using the default parameters:
// CARGA_MAX=15, CARGA_INI=15 and PASO_TICKS=4. Inputs change 1 ns after a
// rising edge. Outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_gestor_carga_baterias;

    logic       clk;
    logic       rst_n;
    logic       cargar;
    logic       consumo;
    logic [3:0] carga_bateria1;
    logic [3:0] carga_bateria2;
    logic [1:0] estado;
    logic       llena;
    logic       vacia;
    logic       actualizado;

    int checks   = 0;
    int failures = 0;

    gestor_carga_baterias dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cargar         (cargar),
        .consumo        (consumo),
        .carga_bateria1 (carga_bateria1),
        .carga_bateria2 (carga_bateria2),
        .estado         (estado),
        .llena          (llena),
        .vacia          (vacia),
        .actualizado    (actualizado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic ticks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] obs,
                               input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkCharges(input string tag, input int e1, input int e2);
        checkOutput({tag, "_c1"}, 8'(carga_bateria1), 8'(e1));
        checkOutput({tag, "_c2"}, 8'(carga_bateria2), 8'(e2));
    endtask

    // Time limit in case the sequence below ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        cargar  = 1'b0;
        consumo = 1'b0;

        // Check the reset state, then idle for 10 clocks.
        ticks(2);
        checkCharges("rst", 15, 15);
        checkOutput("rst_estado", 8'(estado), 8'd0);
        checkOutput("rst_llena", 8'(llena), 8'd1);
        checkOutput("rst_vacia", 8'(vacia), 8'd0);
        checkOutput("rst_act", 8'(actualizado), 8'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ticks(1);
            checkOutput($sformatf("idle%0d_act", i), 8'(actualizado), 8'd0);
        end
        checkCharges("idle", 15, 15);
        checkOutput("idle_estado", 8'(estado), 8'd0);
        checkOutput("idle_llena", 8'(llena), 8'd1);

        // Discharge from 15/15 all the way down to AGOTADO.
        // After k steps the charges are 15-(k+1)/2 and 15-k/2.
        consumo = 1'b1;
        ticks(1);
        checkOutput("dis_entry_estado", 8'(estado), 8'd2);
        checkCharges("dis_entry", 15, 15);
        for (int k = 1; k <= 30; k++) begin
            ticks(3);
            checkOutput($sformatf("dis%0d_pre_act", k), 8'(actualizado), 8'd0);
            ticks(1);
            checkOutput($sformatf("dis%0d_act", k), 8'(actualizado), 8'd1);
            checkCharges($sformatf("dis%0d", k), 15 - (k + 1) / 2, 15 - k / 2);
            checkOutput($sformatf("dis%0d_estado", k), 8'(estado),
                        (k == 30) ? 8'd3 : 8'd2);
        end
        checkOutput("agot_vacia", 8'(vacia), 8'd1);

        // AGOTADO ignores consumo and leaves only when cargar rises.
        consumo = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ticks(1);
            checkOutput($sformatf("agot%0d_estado", i), 8'(estado), 8'd3);
        end
        checkCharges("agot", 0, 0);

        // Charge from 0/0 up to 15/15. This exercises the tie and
        // alternation rules: after t steps the charges are (t+1)/2 and t/2.
        cargar = 1'b1;
        ticks(1);
        checkOutput("chg_entry_estado", 8'(estado), 8'd1);
        for (int t = 1; t <= 30; t++) begin
            ticks(3);
            checkOutput($sformatf("chg%0d_pre_act", t), 8'(actualizado), 8'd0);
            ticks(1);
            checkOutput($sformatf("chg%0d_act", t), 8'(actualizado), 8'd1);
            checkCharges($sformatf("chg%0d", t), (t + 1) / 2, t / 2);
        end
        for (int i = 0; i < 8; i++) begin
            ticks(1);
            checkOutput($sformatf("full%0d_act", i), 8'(actualizado), 8'd0);
        end
        checkOutput("full_estado", 8'(estado), 8'd1);
        checkOutput("full_llena", 8'(llena), 8'd1);
        checkCharges("full", 15, 15);

        // With cargar and consumo both high, CARGANDO wins. Dropping cargar
        // when the tick count is 3 moves to DESCARGANDO and the counter
        // restarts.
        rst_n  = 1'b0;
        cargar = 1'b0;
        #2;
        rst_n = 1'b1;
        ticks(1);
        cargar  = 1'b1;
        consumo = 1'b1;
        ticks(1);
        checkOutput("both_estado", 8'(estado), 8'd1);
        ticks(3);
        checkCharges("both_t3", 15, 15);
        checkOutput("both_t3_act", 8'(actualizado), 8'd0);
        cargar = 1'b0;
        ticks(1);
        checkOutput("both_drop_estado", 8'(estado), 8'd2);
        checkCharges("both_drop", 15, 15);
        ticks(3);
        checkCharges("both_restart_pre", 15, 15);
        ticks(1);
        checkCharges("both_restart", 14, 15);
        checkOutput("both_restart_act", 8'(actualizado), 8'd1);

        // Raising cargar on a would-be discharge edge cancels that step.
        ticks(3);
        cargar = 1'b1;
        ticks(1);
        checkOutput("cancel_estado", 8'(estado), 8'd1);
        checkCharges("cancel", 14, 15);
        checkOutput("cancel_act", 8'(actualizado), 8'd0);
        ticks(3);
        checkCharges("cancel_pre", 14, 15);
        ticks(1);
        checkCharges("cancel_chg", 15, 15);
        checkOutput("cancel_chg_llena", 8'(llena), 8'd1);

        // Apply an asynchronous reset in the middle of a discharge at 9/10.
        cargar = 1'b0;
        ticks(1);
        checkOutput("mid_estado", 8'(estado), 8'd2);
        ticks(44);
        checkCharges("mid", 9, 10);
        checkOutput("mid_act", 8'(actualizado), 8'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkCharges("async", 15, 15);
        checkOutput("async_estado", 8'(estado), 8'd0);
        checkOutput("async_act", 8'(actualizado), 8'd0);
        checkOutput("async_llena", 8'(llena), 8'd1);
        #3;
        consumo = 1'b0;
        rst_n   = 1'b1;
        ticks(2);
        checkCharges("post", 15, 15);
        checkOutput("post_estado", 8'(estado), 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gestor_carga_baterias.md
Name: gestor_carga_baterias

Overview:
- Sequential producer of the two 4-bit battery-charge buses that the charge-level monitor consumes. It drives the writer side of that interface.
- Holds the charge of battery 1 and battery 2 in registers and models the battery pair over time:
  - charging from an external charger;
  - discharging under load, one unit every PASO_TICKS clocks;
  - balancing the pair by always charging the emptier battery and draining the fuller one.
- Publishes an operating state and a one-cycle update strobe for downstream logging.

Parameters:
- CARGA_MAX, 15, saturation value of each battery register (4-bit, ≤ 15). The summed charge is at most 30, which matches the monitor's 5-bit sum.
- CARGA_INI, 15, reset value of both charge registers (≤ CARGA_MAX).
- PASO_TICKS, 4, clocks per charge/discharge step (≥ 1). The tick counter is sized to $clog2(PASO_TICKS)+1 bits.

Ports:
- clk, input, 1, single system clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- cargar, input, 1, charger connected; level-sensitive; has priority over consumo.
- consumo, input, 1, load active; level-sensitive.
- carga_bateria1, output, 4, battery 1 charge register.
- carga_bateria2, output, 4, battery 2 charge register.
- estado, output, 2, 0=REPOSO, 1=CARGANDO, 2=DESCARGANDO, 3=AGOTADO.
- llena, output, 1, both batteries at CARGA_MAX (combinational from registers).
- vacia, output, 1, both batteries at 0 (combinational from registers).
- actualizado, output, 1, one-cycle pulse, registered; high in the cycle where a changed charge value first appears.

Behaviour:
- Reset (async, rst_n=0):
  - carga_bateria1 = carga_bateria2 = CARGA_INI;
  - estado = REPOSO; tick counter = 0; actualizado = 0;
  - llena and vacia follow the registers. With defaults, llena=1 and vacia=0.
- State transitions are evaluated every clock from cargar/consumo sampled at the edge. The tick counter clears on every state change.
  - REPOSO: cargar=1 → CARGANDO. Else if consumo=1, go to DESCARGANDO if not vacia, otherwise to AGOTADO. Else stay.
  - CARGANDO: cargar=0 and consumo=1 → DESCARGANDO (or AGOTADO if vacia). cargar=0 and consumo=0 → REPOSO. Else stay.
  - DESCARGANDO: cargar=1 → CARGANDO. consumo=0 → REPOSO. Otherwise, at the step edge that makes both charges 0 → AGOTADO (same edge).
  - AGOTADO: exits only on cargar=1 → CARGANDO. consumo is ignored.
- Tick counter:
  - Counts only in CARGANDO/DESCARGANDO when no transition is taken.
  - When it equals PASO_TICKS-1, it wraps to 0 and a step is applied on that edge.
  - The first step therefore lands PASO_TICKS clocks after the state-entry edge.
- Charging step:
  - Increment the battery with the lower charge; on a tie, battery 1.
  - A battery already at CARGA_MAX is never incremented. If it is the lower one, the other battery is chosen.
  - If llena, no change and no actualizado. The state stays CARGANDO.
- Discharging step:
  - Decrement the battery with the higher charge; on a tie, battery 1.
  - Never decrement below 0.
- Step/state-change conflict: a state change on the same edge as a would-be step cancels the step.
- actualizado: set to 1 on any edge where either charge register changes value; 0 otherwise.
- Widths: all charge arithmetic is 4-bit unsigned with explicit saturation. There is no wrap-around at either 0 or 15.
- Reset mid-step: the async reset overrides everything immediately. No partial step survives.

Test Plan:
- Reset with defaults, cargar=consumo=0 for 10 clocks → charges 15/15, estado=0, llena=1, actualizado never high.
- consumo=1 held from reset values, PASO_TICKS=4 → estado=2 one edge later. First decrement 4 clocks after entry gives 14/15, next gives 14/14, then 13/14. Each step has a single actualizado pulse.
- consumo=1 held until both charges reach 0 → on the edge giving 0/0, estado=3 and vacia=1. Dropping consumo keeps AGOTADO. Raising cargar → CARGANDO, then 4 clocks later charges 1/0.
- From 3/7 with cargar=1 → increments go to battery 1 (4/7 … 7/7), then alternate 8/7, 8/8. At 15/15 llena=1, estado stays 1, no further actualizado.
- cargar and consumo both 1 from 15/15 → CARGANDO wins, charges unchanged. Drop cargar at tick count 3 → DESCARGANDO on that edge, step cancelled, counter restarts.
- Assert rst_n=0 asynchronously mid-discharge at 9/10 → outputs return to 15/15 and REPOSO before the next clock edge.
